// File: rtl/imm_pkg.sv
// Shared types for the immediate-decode stage: format classes and base-ISA opcodes.
// Pure declarations, no logic, no latency.
// Optional SYSTEM/CSR immediate decode is enabled by defining IMMGEN_CSR_EN.
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_ISH  = 3'd2,
      FMT_S    = 3'd3,
      FMT_B    = 3'd4,
      FMT_U    = 3'd5,
      FMT_J    = 3'd6,
      FMT_Z    = 3'd7
   } imm_fmt_t;

   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // Shift-immediate instructions are SLLI (001) and SRLI/SRAI (101).
   function automatic logic is_shift_funct3(input logic [2:0] funct3);
      return (funct3 == 3'b001) || (funct3 == 3'b101);
   endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extractor: instr -> {imm, fmt, illegal} at XLEN width.
// Zero latency; no state, no handshake.
// Define IMMGEN_CSR_EN to decode SYSTEM CSR immediates (FMT_Z / CSR address).
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output imm_fmt_t        fmt,
   output logic            illegal
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_extract: XLEN must be 32 or 64");
   end

   localparam bit IS_RV64 = (XLEN == 64);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            shift_op;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm_j;
   logic [XLEN-1:0] imm_sh;
   logic [XLEN-1:0] imm_sh32;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign shift_op = is_shift_funct3(funct3);

   // Every signed immediate is sign-extended arithmetically to the full XLEN.
   assign imm_i    = XLEN'($signed(instr[31:20]));
   assign imm_s    = XLEN'($signed({instr[31:25], instr[11:7]}));
   assign imm_b    = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
   assign imm_u    = XLEN'($signed({instr[31:12], 12'b0}));
   assign imm_j    = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
   // Native shamt is 6 bits on RV64, 5 bits on RV32; W-shifts always use 5.
   assign imm_sh   = IS_RV64 ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
   assign imm_sh32 = XLEN'(instr[24:20]);

`ifdef IMMGEN_CSR_EN
   logic [XLEN-1:0] imm_z;
   assign imm_z = XLEN'(instr[19:15]);
`endif

   // Opcode-driven format select; unknown encodings fall to FMT_NONE + illegal.
   always_comb begin
      imm     = '0;
      fmt     = FMT_NONE;
      illegal = 1'b0;
      case (opcode)
         OPC_OP_IMM: begin
            if (shift_op) begin
               fmt     = FMT_ISH;
               imm     = imm_sh;
               illegal = !IS_RV64 && instr[25];
            end else begin
               fmt = FMT_I;
               imm = imm_i;
            end
         end
         OPC_LOAD, OPC_JALR: begin
            fmt = FMT_I;
            imm = imm_i;
         end
         OPC_STORE: begin
            fmt = FMT_S;
            imm = imm_s;
         end
         OPC_BRANCH: begin
            fmt = FMT_B;
            imm = imm_b;
         end
         OPC_LUI, OPC_AUIPC: begin
            fmt = FMT_U;
            imm = imm_u;
         end
         OPC_JAL: begin
            fmt = FMT_J;
            imm = imm_j;
         end
         OPC_OP_IMM32: begin
            if (!IS_RV64) begin
               illegal = 1'b1;
            end else if (shift_op) begin
               fmt     = FMT_ISH;
               imm     = imm_sh32;
               illegal = instr[25];
            end else begin
               fmt = FMT_I;
               imm = imm_i;
            end
         end
         OPC_SYSTEM: begin
`ifdef IMMGEN_CSR_EN
            if (funct3[2] && (funct3[1:0] != 2'b00)) begin
               fmt = FMT_Z;
               imm = imm_z;
            end else begin
               fmt = FMT_I;
               imm = imm_i;
            end
`else
            // Without CSR support SYSTEM is passed through as legal, no immediate.
            fmt     = FMT_NONE;
            illegal = 1'b0;
`endif
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a 2-entry (main + skid) buffer.
// Latency 1 cycle; full throughput while out_ready=1; in_ready = !skid occupied (registered).
// Define IMMGEN_CSR_EN to enable SYSTEM/CSR immediate decode in imm_extract.
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output imm_fmt_t         out_fmt,
   output logic             out_illegal,
   output logic [31:0]      out_instr,
   output logic [TAG_W-1:0] out_tag
);

   logic [XLEN-1:0]  dec_imm;
   imm_fmt_t         dec_fmt;
   logic             dec_illegal;

   logic             main_valid;
   logic             skid_valid;
   logic [XLEN-1:0]  skid_imm;
   imm_fmt_t         skid_fmt;
   logic             skid_illegal;
   logic [31:0]      skid_instr;
   logic [TAG_W-1:0] skid_tag;

   logic             accept;
   logic             drain;
   logic             load_main_in;
   logic             load_main_skid;
   logic             load_skid;
   logic             main_valid_nxt;
   logic             skid_valid_nxt;

   imm_extract #(
      .XLEN (XLEN)
   ) u_extract (
      .instr   (in_instr),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_illegal)
   );

   assign out_valid = main_valid;
   assign accept    = in_valid && in_ready;
   assign drain     = main_valid && out_ready;

   // Steer beats: skid refills main first; a new beat goes to main if it is free
   // or draining this cycle, otherwise it parks in skid. Flush overrides all.
   always_comb begin
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      main_valid_nxt = main_valid;
      skid_valid_nxt = skid_valid;
      if (flush) begin
         main_valid_nxt = 1'b0;
         skid_valid_nxt = 1'b0;
      end else begin
         if (skid_valid) begin
            if (drain) begin
               load_main_skid = 1'b1;
               skid_valid_nxt = 1'b0;
            end
         end else if (accept) begin
            if (!main_valid || drain) begin
               load_main_in = 1'b1;
            end else begin
               load_skid      = 1'b1;
               skid_valid_nxt = 1'b1;
            end
         end else if (drain) begin
            main_valid_nxt = 1'b0;
         end
         if (load_main_in || load_main_skid) begin
            main_valid_nxt = 1'b1;
         end
      end
   end

   // Valid bits and the registered ready; ready opens on the first edge after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b0;
      end else begin
         main_valid <= main_valid_nxt;
         skid_valid <= skid_valid_nxt;
         in_ready   <= !skid_valid_nxt;
      end
   end

   // Main (output) data register, loaded from the decoder or from skid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_imm     <= '0;
         out_fmt     <= FMT_NONE;
         out_illegal <= 1'b0;
         out_instr   <= '0;
         out_tag     <= '0;
      end else if (load_main_in) begin
         out_imm     <= dec_imm;
         out_fmt     <= dec_fmt;
         out_illegal <= dec_illegal;
         out_instr   <= in_instr;
         out_tag     <= in_tag;
      end else if (load_main_skid) begin
         out_imm     <= skid_imm;
         out_fmt     <= skid_fmt;
         out_illegal <= skid_illegal;
         out_instr   <= skid_instr;
         out_tag     <= skid_tag;
      end
   end

   // Skid data register, captured only when main is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_imm     <= '0;
         skid_fmt     <= FMT_NONE;
         skid_illegal <= 1'b0;
         skid_instr   <= '0;
         skid_tag     <= '0;
      end else if (load_skid) begin
         skid_imm     <= dec_imm;
         skid_fmt     <= dec_fmt;
         skid_illegal <= dec_illegal;
         skid_instr   <= in_instr;
         skid_tag     <= in_tag;
      end
   end

endmodule
